// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared constants and helpers for the vmem display scan-out engine.
//   - Default frame-buffer geometry and VGA-style porch/sync lengths.
//   - DISP_SCALE: 1, or 2 when VMEM_DISP_SCALE2_EN is defined (2x2 pixel
//     replication).
//   - disp_ctrl_t: per-pixel control bits carried down the scan pipeline.
//   - disp_total / disp_cnt_w: line/frame length and counter width helpers.
// `VMEM_ADDRW normally comes from the project config header; a default is
// provided here only when nothing defined it earlier.
// -----------------------------------------------------------------------------
`ifndef VMEM_ADDRW
`define VMEM_ADDRW 14
`endif

package disp_pkg;

    localparam int unsigned DISP_VMEM_W = 128;
    localparam int unsigned DISP_VMEM_H = 128;
    localparam int unsigned DISP_H_FP   = 16;
    localparam int unsigned DISP_H_SYNC = 96;
    localparam int unsigned DISP_H_BP   = 48;
    localparam int unsigned DISP_V_FP   = 10;
    localparam int unsigned DISP_V_SYNC = 2;
    localparam int unsigned DISP_V_BP   = 33;

`ifdef VMEM_DISP_SCALE2_EN
    localparam int unsigned DISP_SCALE = 2;
`else
    localparam int unsigned DISP_SCALE = 1;
`endif

    // Control bits for one output pixel; hs/vs are active-high internally.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic first;
    } disp_ctrl_t;

    // Length of a line or frame: active region followed by porches and sync.
    function automatic int unsigned disp_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // Width of a counter that holds 0..n-1 (at least one bit).
    function automatic int unsigned disp_cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vmem_raster_timing.sv
// -----------------------------------------------------------------------------
// vmem_raster_timing
// Pixel-clock divider, horizontal/vertical position counters and the
// per-position control decode for the display scan-out engine.
// Config macro: VMEM_DISP_SCALE2_EN (doubles the active width/height).
// Ports:
//   clk_i, rst_ni   system clock, asynchronous active-low reset
//   h_cnt_o         current horizontal position (pixels)
//   v_cnt_o         current vertical position (lines)
//   line_end_o      last divider cycle of the last pixel of a line
//   frame_end_o     last divider cycle of the last pixel of a frame
//   ctrl_o          combinational {active, hs, vs, first} for this position
// -----------------------------------------------------------------------------
module vmem_raster_timing
    import disp_pkg::*;
#(
    parameter  int unsigned VMEM_W   = DISP_VMEM_W,
    parameter  int unsigned VMEM_H   = DISP_VMEM_H,
    parameter  int unsigned CLK_DIV  = 1,
    parameter  int unsigned H_FP     = DISP_H_FP,
    parameter  int unsigned H_SYNC   = DISP_H_SYNC,
    parameter  int unsigned H_BP     = DISP_H_BP,
    parameter  int unsigned V_FP     = DISP_V_FP,
    parameter  int unsigned V_SYNC   = DISP_V_SYNC,
    parameter  int unsigned V_BP     = DISP_V_BP,
    localparam int unsigned H_ACTIVE = VMEM_W * DISP_SCALE,
    localparam int unsigned V_ACTIVE = VMEM_H * DISP_SCALE,
    localparam int unsigned H_TOTAL  = disp_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int unsigned V_TOTAL  = disp_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int unsigned H_CW     = disp_cnt_w(H_TOTAL),
    localparam int unsigned V_CW     = disp_cnt_w(V_TOTAL)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic [H_CW-1:0] h_cnt_o,
    output logic [V_CW-1:0] v_cnt_o,
    output logic            line_end_o,
    output logic            frame_end_o,
    output disp_ctrl_t      ctrl_o
);

    localparam int unsigned DIV_W    = disp_cnt_w(CLK_DIV);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [H_CW-1:0]  h_cnt_q, h_cnt_d;
    logic [V_CW-1:0]  v_cnt_q, v_cnt_d;
    logic             tick, h_last, v_last;
    logic [31:0]      h_ext, v_ext;

    assign tick   = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign h_last = (h_cnt_q == H_CW'(H_TOTAL - 1));
    assign v_last = (v_cnt_q == V_CW'(V_TOTAL - 1));

    // Region compares are done at 32 bits so an end bound equal to 2^H_CW
    // (zero back porch) cannot alias to 0.
    assign h_ext = 32'(h_cnt_q);
    assign v_ext = 32'(v_cnt_q);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        if (tick) begin
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? '0 : v_cnt_q + V_CW'(1);
            end else begin
                h_cnt_d = h_cnt_q + H_CW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments and an asynchronous
    // active-low reset in the sensitivity list.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
        end
    end

    assign h_cnt_o     = h_cnt_q;
    assign v_cnt_o     = v_cnt_q;
    assign line_end_o  = tick && h_last;
    assign frame_end_o = tick && h_last && v_last;

    // first is qualified with div_cnt==0 so it marks only the first clk of
    // pixel (0,0) when the divider stretches each pixel.
    assign ctrl_o = '{
        active: (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE),
        hs:     (h_ext >= HS_START) && (h_ext < HS_END),
        vs:     (v_ext >= VS_START) && (v_ext < VS_END),
        first:  (h_cnt_q == '0) && (v_cnt_q == '0) && (div_cnt_q == '0)
    };

endmodule

// File: rtl/vmem_disp_scan.sv
// -----------------------------------------------------------------------------
// vmem_disp_scan
// Raster scan-out engine for the display side of the video memory. Generates
// pixel timing, drives the vmem display read port and returns a registered
// 3-bit pixel stream with syncs and data-enable, 3 clk behind the counters.
// Config macro: VMEM_DISP_SCALE2_EN (replicate each vmem pixel 2x2).
// Ports:
//   clk_i, rst_ni     system clock (same as vmem), async active-low reset
//   disp_raddr_o      vmem read address (0 during blanking)
//   disp_rdata_i      vmem read data, valid one clk after its address
//   rgb_o             pixel colour {R,G,B}, 0 outside active video
//   de_o              active-video enable
//   hsync_o, vsync_o  syncs, active-low
//   frame_start_o     one-clk pulse with output pixel (0,0)
// -----------------------------------------------------------------------------
module vmem_disp_scan
    import disp_pkg::*;
#(
    parameter int unsigned VMEM_W  = DISP_VMEM_W,
    parameter int unsigned VMEM_H  = DISP_VMEM_H,
    parameter int unsigned CLK_DIV = 1,
    parameter int unsigned H_FP    = DISP_H_FP,
    parameter int unsigned H_SYNC  = DISP_H_SYNC,
    parameter int unsigned H_BP    = DISP_H_BP,
    parameter int unsigned V_FP    = DISP_V_FP,
    parameter int unsigned V_SYNC  = DISP_V_SYNC,
    parameter int unsigned V_BP    = DISP_V_BP
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    output logic [`VMEM_ADDRW-1:0] disp_raddr_o,
    input  logic [2:0]             disp_rdata_i,
    output logic [2:0]             rgb_o,
    output logic                   de_o,
    output logic                   hsync_o,
    output logic                   vsync_o,
    output logic                   frame_start_o
);

    localparam int unsigned ADDRW    = `VMEM_ADDRW;
    localparam int unsigned H_ACTIVE = VMEM_W * DISP_SCALE;
    localparam int unsigned V_ACTIVE = VMEM_H * DISP_SCALE;
    localparam int unsigned H_TOTAL  = disp_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL  = disp_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned H_CW     = disp_cnt_w(H_TOTAL);
    localparam int unsigned V_CW     = disp_cnt_w(V_TOTAL);

    logic [H_CW-1:0]  h_cnt, col;
    logic [V_CW-1:0]  v_cnt;
    logic [31:0]      v_ext;
    logic             line_end, frame_end, row_done;
    disp_ctrl_t       ctrl;

    logic [ADDRW-1:0] line_base_q, line_base_d;
    logic [ADDRW-1:0] raddr_q, raddr_d;
    disp_ctrl_t       s1_ctrl_q, s2_ctrl_q;
    logic [2:0]       rgb_q;
    logic             de_q, hsync_q, vsync_q, frame_start_q;

    vmem_raster_timing #(
        .VMEM_W  (VMEM_W),
        .VMEM_H  (VMEM_H),
        .CLK_DIV (CLK_DIV),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP)
    ) u_timing (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .h_cnt_o     (h_cnt),
        .v_cnt_o     (v_cnt),
        .line_end_o  (line_end),
        .frame_end_o (frame_end),
        .ctrl_o      (ctrl)
    );

    assign v_ext = 32'(v_cnt);

    // A row of vmem is consumed once per active line, or once per pair of
    // lines when scaling (the odd line closes the pair).
`ifdef VMEM_DISP_SCALE2_EN
    assign row_done = line_end && (v_ext < V_ACTIVE) && v_cnt[0];
    assign col      = h_cnt >> 1;
`else
    assign row_done = line_end && (v_ext < V_ACTIVE);
    assign col      = h_cnt;
`endif

    // line_base tracks the row start by accumulation instead of v*VMEM_W;
    // all additions wrap modulo the address width.
    always_comb begin
        line_base_d = line_base_q;
        if (frame_end) begin
            line_base_d = '0;
        end else if (row_done) begin
            line_base_d = line_base_q + ADDRW'(VMEM_W);
        end
        raddr_d = ctrl.active ? line_base_q + ADDRW'(col) : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_base_q <= '0;
        end else begin
            line_base_q <= line_base_d;
        end
    end

    // S1 address/control, S2 control waits for the vmem read, S3 output.
    // A cleared control word decodes to blank with syncs deasserted, so the
    // outputs stay at their idle levels until the first real pixel arrives.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            raddr_q       <= '0;
            s1_ctrl_q     <= '0;
            s2_ctrl_q     <= '0;
            rgb_q         <= 3'd0;
            de_q          <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            raddr_q       <= raddr_d;
            s1_ctrl_q     <= ctrl;
            s2_ctrl_q     <= s1_ctrl_q;
            rgb_q         <= s2_ctrl_q.active ? disp_rdata_i : 3'd0;
            de_q          <= s2_ctrl_q.active;
            hsync_q       <= ~s2_ctrl_q.hs;
            vsync_q       <= ~s2_ctrl_q.vs;
            frame_start_q <= s2_ctrl_q.first;
        end
    end

    assign disp_raddr_o  = raddr_q;
    assign rgb_o         = rgb_q;
    assign de_o          = de_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: doc/vmem_disp_scan.md
# vmem_disp_scan

Raster scan-out engine on the display side of the video memory. It generates pixel timing (hsync/vsync/data-enable) and drives the vmem display read port (`disp_raddr` / `disp_rdata`). It converts the 3-bit pixels returned into a registered pixel stream for the panel/VGA PHY. It is the sole consumer of the vmem read port; core writes arrive independently through the dbus arbiter.

## Interface
- `VMEM_W`, 128: frame-buffer width in vmem pixels.
- `VMEM_H`, 128: frame-buffer height in vmem pixels.
- `CLK_DIV`, 1: `clk_i` cycles per output pixel (≥1).
- `H_FP`, `H_SYNC`, `H_BP`, 16/96/48: horizontal porch and sync lengths, in pixels.
- `V_FP`, `V_SYNC`, `V_BP`, 10/2/33: vertical porch and sync lengths, in lines.
- `clk_i`  in  1  system clock, the same clock as vmem.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `disp_raddr_o`  out  `` `VMEM_ADDRW``  vmem read address.
- `disp_rdata_i`  in  3  vmem read data; valid one `clk_i` after its address.
- `rgb_o`  out  3  pixel colour {R,G,B}.
- `de_o`  out  1  active-video enable.
- `hsync_o`, `vsync_o`  out  1  syncs, active-low.
- `frame_start_o`  out  1  one-clk pulse coincident with output pixel (0,0).

## Operation
- **Pixel tick.** `div_cnt` counts 0..`CLK_DIV`-1; `tick` = (`div_cnt`==`CLK_DIV`-1).
- **Position counters.** `h_cnt` and `v_cnt` advance only on `tick`.
  - `h_cnt` runs 0..H_TOTAL-1 and wraps to 0 with `v_cnt`+1.
  - `v_cnt` wraps to 0 after V_TOTAL-1.
- **Line order.** Each line and each frame runs active, front porch, sync, back porch.
  - H_ACTIVE = `VMEM_W`·S and V_ACTIVE = `VMEM_H`·S, where S = 1, or S = 2 with scaling enabled.
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- **Addressing.** No multiplier is used.
  - `line_base` holds the address of the current row's first pixel.
  - It advances by `VMEM_W` at the end of every contributing active line and clears at frame wrap.
  - Address = `line_base` + (`h_cnt`>>(S-1)), truncated to `` `VMEM_ADDRW``.
  - During blanking the address is 0.
- **Pipeline.** The pipeline is clk-rate, 3 stages, independent of `tick`.
  - S1 registers the address and the control bits {active, hs, vs, first}.
  - S2 delays the control bits while vmem reads.
  - S3 registers `rgb_o` = active ? `disp_rdata_i` : 0, together with `de_o`, `hsync_o`, `vsync_o` and `frame_start_o`.
- **Frame-start pulse.** `frame_start_o` is high for exactly one clk: the first S3 cycle for position (0,0). With `CLK_DIV`>1 the pixel persists, but the pulse does not.
- **Writes during scan-out.** Writes to vmem are not synchronised with scan. A pixel written mid-frame appears when next scanned; tearing is accepted.

## Timing
- **Reset values.** `disp_raddr_o`=0, `rgb_o`=0, `de_o`=0, `hsync_o`=1, `vsync_o`=1, `frame_start_o`=0.
- **Counter reset.** All counters and `line_base` reset to 0.
- **Fixed latency.** Outputs lag a counter change by 3 clk.
- **First pixel.** With `CLK_DIV`=1, `de_o` first rises at the 3rd rising edge after `rst_ni` deasserts.
- **Sync timing.**
  - `hsync_o` is low for exactly H_SYNC·`CLK_DIV` clk per line.
  - `vsync_o` is low for V_SYNC whole lines.
  - Both are aligned to `h_cnt`=0 of their line/position.
- **Reset mid-frame.** Outputs go to their reset values immediately (asynchronously). The scan restarts at (0,0); there are no partial-frame artefacts beyond the truncated frame.
- **Address wrap.** An address beyond 2^`` `VMEM_ADDRW``-1 wraps modulo the address width. Not an error.

## Configuration
- **`VMEM_DISP_SCALE2_EN` defined.** Each vmem pixel is replicated 2×2.
  - H_ACTIVE = 2·`VMEM_W`; `line_base` advances only after odd active lines.
  - The address uses `h_cnt`>>1.
- **`VMEM_DISP_SCALE2_EN` undefined.** 1:1 mapping; the scale logic is absent.

## Structure
- **Shared constants.** Default timing constants and H_TOTAL/V_TOTAL derivation go in a shared `disp_pkg` package. `` `VMEM_ADDRW`` still comes from `config.vh`.
- **Sub-module `vmem_raster_timing`.** Contains the divider, `h_cnt`/`v_cnt`, and the active/hs/vs/first decode.
- **Top-level contents.** `line_base`, address generation and the 3-stage pipeline.

## Test plan
Benches use `VMEM_W`=4, `VMEM_H`=3, H_FP=1, H_SYNC=2, H_BP=1, V_FP=1, V_SYNC=1, V_BP=1, so H_TOTAL=8 and V_TOTAL=6. The vmem model is preloaded with mem[a]=a[2:0].
- **Reset and first frame.** Release `rst_ni` with `CLK_DIV`=1.
  - `frame_start_o` pulses after edge 3.
  - `rgb_o` = 0,1,2,3 with `de_o`=1, then 4 clk of `de_o`=0.
- **Sync widths.** Run 2 frames.
  - `hsync_o` is low 2 clk per 8.
  - `vsync_o` is low for 8 clk per 48.
  - `frame_start_o` pulses every 48 clk.
- **Addressing.** Row 2 reads addresses 8..11 → `rgb_o` 0,1,2,3.
  - `disp_raddr_o`=0 during blanking.
- **Divider.** With `CLK_DIV`=3, each pixel holds 3 clk and the frame is 144 clk.
  - `frame_start_o` stays a single-clk pulse.
- **Reset mid-frame.** Assert `rst_ni` low at row 1, col 2.
  - Outputs go to their reset values immediately.
  - After release, the scan restarts at (0,0) with identical timing to the first case.
- **Scaling.** With `VMEM_DISP_SCALE2_EN` defined, line 0 outputs 0,0,1,1,2,2,3,3.
  - Line 1 repeats line 0; line 2 starts at address 4.
